dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_starve_cnt.sv | 23 ++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths and FSM encoding for the data-memory arbiter
package dmem_arb_pkg;
    localparam int STARVE_W = 8;
    localparam int DW = 32;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        CPU_DONE = 2'd2,
        DMA_BUSY = 2'd3
    } state_t;
endpackage

// File: rtl/dmem_starve_cnt.sv
// dmem_starve_cnt: saturating DMA wait counter with threshold compare
// Ports: clk, rst_n (sync active-low), inc, clr (clr dominates), hit (count >= STARVE_MAX)
module dmem_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    logic [STARVE_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign hit = cnt_q >= STARVE_W'(STARVE_MAX);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter between the MEM stage and an optional DMA
// Ports: CLK, RESET (sync active-low); MEM-stage MemRead_in/MemWrite_in/addr_in/wdata_in,
// cpu_rdata, FREEZE; registered memory request mem_req/mem_we/mem_addr/mem_wdata with
// mem_ack/mem_rdata; DMA dma_req/dma_we/dma_addr/dma_wdata/dma_gnt/dma_done/dma_rdata
// present only when DMEM_ARB_DMA_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          MemRead_in,
    input  logic          MemWrite_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic [DW-1:0] cpu_rdata,
    output logic          FREEZE,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_DMA_EN
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [DW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
`endif
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..255");
    end

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_req;

    assign cpu_req = MemRead_in | MemWrite_in;

`ifdef DMEM_ARB_DMA_EN
    logic          dma_gnt_q, dma_gnt_d, dma_done_q, dma_done_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          starve_hit, dma_win, grant;

    // DMA takes an idle slot, or overrides a pending CPU request once starved.
    assign dma_win = dma_req && (!cpu_req || starve_hit);
    assign grant   = state_q == IDLE && dma_win;

    dmem_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (dma_req && !grant),
        .clr   (grant || !dma_req),
        .hit   (starve_hit)
    );
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
`ifdef DMEM_ARB_DMA_EN
        dma_gnt_d   = 1'b0;
        dma_done_d  = 1'b0;
        dma_rdata_d = dma_rdata_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_ARB_DMA_EN
                if (dma_win) begin
                    state_d     = DMA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    dma_gnt_d   = 1'b1;
                end else
`endif
                if (cpu_req) begin
                    state_d     = CPU_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite_in;
                    mem_addr_d  = addr_in;
                    mem_wdata_d = wdata_in;
                end
            end
            CPU_BUSY: begin
                if (mem_ack) begin
                    state_d     = CPU_DONE;
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = mem_we_q ? cpu_rdata_q : mem_rdata;
                end
            end
            CPU_DONE: state_d = IDLE;
            default: begin
`ifdef DMEM_ARB_DMA_EN
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    dma_done_d  = 1'b1;
                    dma_rdata_d = mem_rdata;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
`ifdef DMEM_ARB_DMA_EN
            dma_gnt_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_rdata_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef DMEM_ARB_DMA_EN
            dma_gnt_q   <= dma_gnt_d;
            dma_done_q  <= dma_done_d;
            dma_rdata_q <= dma_rdata_d;
`endif
        end
    end

    // The CPU is released only in CPU_DONE; a pending request stalls every other state.
    assign FREEZE    = cpu_req && state_q != CPU_DONE;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
`ifdef DMEM_ARB_DMA_EN
    assign dma_gnt   = dma_gnt_q;
    assign dma_done  = dma_done_q;
    assign dma_rdata = dma_rdata_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic [31:0] cpu_rdata;
    logic        FREEZE, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_DMA_EN
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt, dma_done;
    logic [31:0] dma_rdata;
`endif
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.STARVE_MAX(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .cpu_rdata   (cpu_rdata),
        .FREEZE      (FREEZE),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
`ifdef DMEM_ARB_DMA_EN
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_done    (dma_done),
        .dma_rdata   (dma_rdata),
`endif
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int frz;
        int we_cnt;
        tick();
        tick();
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_frz", FREEZE, 0);
        RESET = 1'b1;
        tick();

        // load, ack in first busy cycle
        frz = 0;
        MemRead_in = 1'b1; addr_in = 32'h100;
        #1;
        chk("ld_frz_idle", FREEZE, 1);
        frz += int'(FREEZE);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", mem_we, 0);
        frz += int'(FREEZE);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("ld_done_frz", FREEZE, 0);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_req_off", mem_req, 0);
        chk("ld_frz_cnt", frz, 2);
        MemRead_in = 1'b0;
        tick();

        // store, ack on the fifth busy cycle
        frz = 0; we_cnt = 0;
        MemWrite_in = 1'b1; addr_in = 32'h204; wdata_in = 32'h12345678;
        #1;
        frz += int'(FREEZE);
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 4); mem_rdata = 32'h55555555;
            #1;
            frz += int'(FREEZE);
            if (mem_req && mem_we && mem_wdata == 32'h12345678 && mem_addr == 32'h204) we_cnt++;
            tick();
        end
        mem_ack = 1'b0;
        #1;
        chk("st_done_frz", FREEZE, 0);
        chk("st_frz_cnt", frz, 6);
        chk("st_we_cnt", we_cnt, 5);
        chk("st_rdata_keep", cpu_rdata, 32'hDEADBEEF);
        chk("st_req_off", mem_req, 0);
        MemWrite_in = 1'b0;
        tick();

        // read+write together is a write
        MemRead_in = 1'b1; MemWrite_in = 1'b1; addr_in = 32'h208; wdata_in = 32'hA5A5A5A5;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        #1;
        chk("rw_we", mem_we, 1);
        chk("rw_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rw_rdata_keep", cpu_rdata, 32'hDEADBEEF);
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        tick();

        // spurious ack in idle
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("sp_frz", FREEZE, 0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("sp_req", mem_req, 0);
        chk("sp_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("sp_frz2", FREEZE, 0);
        tick();

        // reset during CPU_BUSY, late ack afterwards
        MemRead_in = 1'b1; addr_in = 32'h300;
        tick();
        #1;
        chk("rb_req", mem_req, 1);
        RESET = 1'b0; MemRead_in = 1'b0;
        tick();
        #1;
        chk("rb_req_off", mem_req, 0);
        chk("rb_rdata", cpu_rdata, 0);
        chk("rb_addr", mem_addr, 0);
        RESET = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rb_ack_ign", cpu_rdata, 0);
        chk("rb_req_idle", mem_req, 0);
        chk("rb_frz", FREEZE, 0);
        tick();

`ifdef DMEM_ARB_DMA_EN
        // DMA with CPU idle
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h400;
        tick();
        #1;
        chk("dma_gnt", dma_gnt, 1);
        chk("dma_req_mem", mem_req, 1);
        chk("dma_addr", mem_addr, 32'h400);
        chk("dma_done_early", dma_done, 0);
        dma_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("dma_gnt_pulse", dma_gnt, 0);
        chk("dma_done", dma_done, 1);
        chk("dma_rdata", dma_rdata, 32'hCAFEF00D);
        chk("dma_req_off", mem_req, 0);
        tick();
        #1;
        chk("dma_done_pulse", dma_done, 0);

        // starvation override under continuous CPU loads
        begin
            int gnt_cyc = -1;
            int done_cyc = -1;
            logic frz_dma = 1'b0;
            logic [31:0] addr_dma = '0;
            MemRead_in = 1'b1; addr_in = 32'h500;
            dma_req = 1'b1; dma_addr = 32'h600;
            for (int c = 0; c < 14; c++) begin
                mem_ack = mem_req; mem_rdata = 32'h0000BEEF;
                #1;
                if (dma_gnt && gnt_cyc < 0) begin
                    gnt_cyc = c; frz_dma = FREEZE; addr_dma = mem_addr;
                end
                if (dma_done && done_cyc < 0) done_cyc = c;
                tick();
            end
            chk("stv_gnt_cyc", gnt_cyc, 10);
            chk("stv_frz", {31'd0, frz_dma}, 1);
            chk("stv_addr", addr_dma, 32'h600);
            chk("stv_done_cyc", done_cyc, 11);
            MemRead_in = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
            tick();
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
